// File: rtl/req_fifo_gen2_if.sv
// Request-path bundle between capture logic (master) and req_fifo_gen2 (slave).
interface req_fifo_gen2_if #(
  parameter int WIDTH = 640,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push_en;
  logic [WIDTH-1:0] data_in;
  logic             pop_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow_err;
  logic             underflow_err;
  logic             err_clr;
  logic [15:0]      drop_cnt;

  modport master (
    output push_en, data_in, pop_en, err_clr,
    input  data_out, empty, full, almost_full, almost_empty, count,
           overflow_err, underflow_err, drop_cnt
  );

  modport slave (
    input  push_en, data_in, pop_en, err_clr,
    output data_out, empty, full, almost_full, almost_empty, count,
           overflow_err, underflow_err, drop_cnt
  );
endinterface

// File: rtl/req_fifo_gen2.sv
// First-word-fall-through request FIFO with occupancy thresholds and sticky errors.
// Define REQ_FIFO_DROP_CNT_EN to build the saturating rejected-push counter.
module req_fifo_gen2 #(
  parameter int WIDTH         = 640,
  parameter int DEPTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input logic            clk,
  input logic            reset_n,
  req_fifo_gen2_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_err_q, overflow_err_d;
  logic             underflow_err_q, underflow_err_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic empty, full, pop_acc, push_acc, push_rej;

  // At full, a push is only taken when a pop frees the head slot in the same cycle.
  always_comb begin
    empty    = (rd_ptr_q == wr_ptr_q);
    full     = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    pop_acc  = bus.pop_en & ~empty;
    push_acc = bus.push_en & (~full | pop_acc);
    push_rej = bus.push_en & ~push_acc;

    rd_ptr_d = rd_ptr_q + PW'(pop_acc);
    wr_ptr_d = wr_ptr_q + PW'(push_acc);
    count_d  = count_q + CW'(push_acc) - CW'(pop_acc);

    overflow_err_d  = push_rej | (overflow_err_q & ~bus.err_clr);
    underflow_err_d = (bus.pop_en & empty) | (underflow_err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push_acc) mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

`ifdef REQ_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A rejection coinciding with err_clr restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.err_clr)
      drop_cnt_d = {15'd0, push_rej};
    else if (push_rej && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.data_out      = mem[rd_ptr_q[AW-1:0]];
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.count         = count_q;
  assign bus.almost_full   = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty  = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.overflow_err  = overflow_err_q;
  assign bus.underflow_err = underflow_err_q;
endmodule

// File: doc/req_fifo_gen2.md
# req_fifo_gen2

Parametrised first-word-fall-through request FIFO for the page access counter request path, succeeding the original request FIFO. It differs from that FIFO in four ways:
- all DEPTH entries are usable;
- occupancy count and programmable almost-full/almost-empty thresholds feed upstream throttling;
- illegal push/pop attempts are reported through sticky error flags;
- simultaneous push and pop at full is defined behaviour.

It sits between the request capture logic and the counter update pipeline.

## Interface
Parameters:
- WIDTH, 640, payload width in bits (≥1)
- DEPTH, 32, entry count; power of two, ≥2
- AFULL_THRESH, DEPTH-4, almost_full asserted when count ≥ AFULL_THRESH (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ AEMPTY_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- push_en  in  1  write request
- data_in  in  WIDTH  write payload
- pop_en  in  1  read request; consumes head entry
- data_out  out  WIDTH  head entry, valid while empty=0
- empty  out  1  count==0
- full  out  1  count==DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow_err  out  1  sticky: push rejected
- underflow_err  out  1  sticky: pop on empty
- err_clr  in  1  clears both sticky flags and drop_cnt
- drop_cnt  out  16  rejected-push counter (see Configuration)

## Operation
- Storage is DEPTH×WIDTH memory. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Status from pointers: empty when the pointers are fully equal. Full when the index bits are equal and the wrap bits differ.
- pop_acc = pop_en & !empty; read pointer increments.
- push_acc = push_en & (!full | pop_acc); write pointer increments and the memory location is written.
  - Push while full is accepted only if a pop is accepted in the same cycle.
- count next = count + push_acc − pop_acc. Never exceeds DEPTH; never underflows.
- Push while full with no accepted pop: push dropped, memory unchanged, overflow_err set.
- Pop while empty: no pointer change, underflow_err set.
  - Push+pop while empty: push accepted; pop ignored; underflow_err set.
- Sticky flags stay set until err_clr or reset.
  - err_clr in the same cycle as a new error: the error wins (flag set).
- data_out is combinational from memory[rd_ptr index] (FWFT). When empty, its value is don't-care.
- Memory contents are not reset.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow_err 0, underflow_err 0, drop_cnt 0, pointers 0.
- Push latency: the entry written at edge N is visible on data_out and reflected in count/empty after edge N (one cycle).
- Pop: data_out advances to the next entry immediately after the popping edge.
- All status outputs are registered, or derived combinationally from registered pointers/count only. There is no combinational path from push_en/pop_en to any output.
- Pointer wrap: indices wrap DEPTH-1→0 and the wrap bit toggles. Full/empty remain correct across any number of wraps.
- Reset asserted mid-operation: on the next edge all state returns to reset values. Entries in flight are discarded.

## Configuration
- Macro REQ_FIFO_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter, incremented on every rejected push.
  - Saturates at 0xFFFF.
  - Cleared by err_clr; a rejected push in the same cycle as err_clr leaves the counter at 1.
- Undefined: drop_cnt is tied to 0 and no counter logic is instantiated. overflow_err behaviour is unchanged.

## Test plan
- Reset, then fill: push 32 distinct values with no pop. Expect:
  - full=1 after the 32nd edge, count=32, almost_full=1 from count 28;
  - popping 32 times returns the values in order;
  - empty=1 and almost_empty=1 at count ≤2.
- Push at full: push_en with pop_en=0 at count=32. Expect:
  - overflow_err=1, count stays 32, head data unchanged;
  - drop_cnt=1 with the macro, 0 without.
- Push+pop at full: 10 consecutive cycles of push+pop. Expect count=32 throughout, no error, output order preserved across the pointer wrap.
- Pop at empty, with and without a simultaneous push. Expect:
  - underflow_err=1 in both cases;
  - with the push, count=1 and data_out equals the pushed value next cycle.
- Error clear and saturation (macro on): force 70000 rejected pushes. Expect drop_cnt=0xFFFF. Then err_clr alone → both flags 0 and drop_cnt=0 next cycle.
- Reset mid-stream: at count=17, assert reset_n=0 for 1 cycle. Expect count=0, empty=1, flags 0. A subsequent push/pop round-trip returns correct data.
